// File: rtl/segdisplay.sv
// +----------------------------------------------------------------------------
// | segdisplay : memory-mapped 8-digit seven-segment writer, falling-edge scan
// | rev 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module segdisplay #(
  parameter int SCAN_DIV = 50000
) (
  input  logic        segclk,
  input  logic        segrst,
  input  logic        segcs,
  input  logic        segwrite,
  input  logic [1:0]  segaddr,
  input  logic [15:0] segwdata,
  output logic [7:0]  seg_an,
  output logic [7:0]  seg_out
);

  localparam int               DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [1:0]       ADDR_LO  = 2'b00;
  localparam logic [1:0]       ADDR_CTL = 2'b01;
  localparam logic [1:0]       ADDR_HI  = 2'b10;

  logic [31:0]      data_q, data_d;
  logic [7:0]       mask_q, mask_d;
  logic [7:0]       dp_q,   dp_d;
  logic [DIV_W-1:0] div_q,  div_d;
  logic [2:0]       idx_q,  idx_d;
  logic [7:0]       an_q,   an_d;
  logic [7:0]       seg_q,  seg_d;

  logic             w_wr;
  logic [3:0]       w_nib;
  logic             w_on;

  // Active-high g..a pattern for one hex nibble.
  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0:    s = 7'h3F;
      4'h1:    s = 7'h06;
      4'h2:    s = 7'h5B;
      4'h3:    s = 7'h4F;
      4'h4:    s = 7'h66;
      4'h5:    s = 7'h6D;
      4'h6:    s = 7'h7D;
      4'h7:    s = 7'h07;
      4'h8:    s = 7'h7F;
      4'h9:    s = 7'h6F;
      4'hA:    s = 7'h77;
      4'hB:    s = 7'h7C;
      4'hC:    s = 7'h39;
      4'hD:    s = 7'h5E;
      4'hE:    s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  assign w_wr = segcs & segwrite;

  always_comb begin
    data_d = data_q;
    mask_d = mask_q;
    dp_d   = dp_q;
    if (w_wr) begin
      case (segaddr)
        ADDR_LO:  data_d[15:0]  = segwdata;
        ADDR_HI:  data_d[31:16] = segwdata;
        ADDR_CTL: begin
          mask_d = segwdata[7:0];
          dp_d   = segwdata[15:8];
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    div_d = div_q + DIV_W'(1);
    idx_d = idx_q;
    if (div_q == DIV_LAST) begin
      div_d = '0;
      idx_d = idx_q + 3'd1;
    end
  end

  // Outputs decode the pre-edge registers, so they trail the index by one edge.
  assign w_nib = data_q[{idx_q, 2'b00} +: 4];
  assign w_on  = mask_q[idx_q];

  always_comb begin
    an_d  = 8'hFF;
    seg_d = 8'hFF;
    if (w_on) begin
      an_d  = ~(8'b1 << idx_q);
      seg_d = {~dp_q[idx_q], ~hex7(w_nib)};
    end
  end

  always_ff @(negedge segclk) begin
    if (!segrst) begin
      data_q <= '0;
      mask_q <= 8'hFF;
      dp_q   <= 8'h00;
      div_q  <= '0;
      idx_q  <= '0;
      an_q   <= 8'hFF;
      seg_q  <= 8'hFF;
    end else begin
      data_q <= data_d;
      mask_q <= mask_d;
      dp_q   <= dp_d;
      div_q  <= div_d;
      idx_q  <= idx_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
    end
  end

  assign seg_an  = an_q;
  assign seg_out = seg_q;

endmodule

`default_nettype wire

// File: tb/tb_segdisplay.sv
// +----------------------------------------------------------------------------
// | tb_segdisplay : directed bench for segdisplay with SCAN_DIV = 4
// | rev 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module tb_segdisplay;

  logic        segclk = 1'b0;
  logic        segrst;
  logic        segcs;
  logic        segwrite;
  logic [1:0]  segaddr;
  logic [15:0] segwdata;
  logic [7:0]  seg_an;
  logic [7:0]  seg_out;

  int total = 0;
  int bad   = 0;
  int ecnt  = 0;  // falling edges since reset release

  logic [7:0] exp_cnt [8];
  logic [7:0] exp_hex [6];

  segdisplay #(.SCAN_DIV(4)) dut (
    .segclk  (segclk),
    .segrst  (segrst),
    .segcs   (segcs),
    .segwrite(segwrite),
    .segaddr (segaddr),
    .segwdata(segwdata),
    .seg_an  (seg_an),
    .seg_out (seg_out)
  );

  always #5 segclk = ~segclk;

  task automatic tick();
    @(negedge segclk);
    #2;
    if (!segrst) ecnt = 0;
    else         ecnt = ecnt + 1;
  endtask

  // Advance to the first edge that displays digit d.
  task automatic goto_digit(input int d);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!(((ecnt - 1) % 4 == 0) && (((ecnt - 1) / 4) % 8 == d)) && n < 64);
  endtask

  task automatic chk(input string tag, input logic [7:0] an_e, input logic [7:0] out_e);
    total++;
    assert (seg_an === an_e) else begin
      bad++;
      $error("FAIL %s seg_an observed=%h expected=%h", tag, seg_an, an_e);
    end
    total++;
    assert (seg_out === out_e) else begin
      bad++;
      $error("FAIL %s seg_out observed=%h expected=%h", tag, seg_out, out_e);
    end
  endtask

  task automatic wr(input logic cs, input logic [1:0] a, input logic [15:0] d);
    segcs    = cs;
    segwrite = 1'b1;
    segaddr  = a;
    segwdata = d;
    tick();
    segcs    = 1'b0;
    segwrite = 1'b0;
  endtask

  initial begin
    exp_cnt = '{8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80};
    exp_hex = '{8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    // reset with a write attempted throughout
    segrst   = 1'b0;
    segcs    = 1'b1;
    segwrite = 1'b1;
    segaddr  = 2'b00;
    segwdata = 16'hFFFF;
    repeat (3) tick();
    chk("reset_dark", 8'hFF, 8'hFF);

    segrst   = 1'b1;
    segcs    = 1'b0;
    segwrite = 1'b0;
    tick();
    chk("post_reset_d0", 8'hFE, 8'hC0);

    // counting pattern 8..1
    wr(1'b1, 2'b00, 16'h4321);
    wr(1'b1, 2'b10, 16'h8765);
    tick();
    chk("cnt_d0", 8'hFE, exp_cnt[0]);
    for (int k = 1; k < 8; k++) begin
      goto_digit(k);
      chk($sformatf("cnt_d%0d", k), ~(8'b1 << k), exp_cnt[k]);
    end
    goto_digit(0);
    chk("cnt_wrap", 8'hFE, exp_cnt[0]);

    // hex letters A..F
    wr(1'b1, 2'b00, 16'hDCBA);
    wr(1'b1, 2'b10, 16'h00FE);
    for (int k = 0; k < 6; k++) begin
      goto_digit(k);
      chk($sformatf("hex_d%0d", k), ~(8'b1 << k), exp_hex[k]);
    end

    // mask digits 0 and 2, dp on digit 0
    wr(1'b1, 2'b01, 16'h0105);
    for (int k = 0; k < 8; k++) begin
      goto_digit(k);
      if (k == 0)      chk("mask_d0", 8'hFE, 8'h08);
      else if (k == 2) chk("mask_d2", 8'hFB, 8'hC6);
      else             chk($sformatf("mask_d%0d", k), 8'hFF, 8'hFF);
    end

    // gated writes leave everything as it was
    wr(1'b0, 2'b00, 16'hFFFF);
    wr(1'b1, 2'b11, 16'hFFFF);
    goto_digit(0);
    chk("gate_d0", 8'hFE, 8'h08);
    goto_digit(2);
    chk("gate_d2", 8'hFB, 8'hC6);

    // write mid-slot: same edge shows old value, next edge the new one
    wr(1'b1, 2'b00, 16'h0900);
    chk("wr_same_edge", 8'hFB, 8'hC6);
    tick();
    chk("wr_next_edge", 8'hFB, 8'h90);
    // mask write on the last edge of slot 2 shows up on the first edge of slot 3
    wr(1'b1, 2'b01, 16'h0008);
    chk("last_edge_old", 8'hFB, 8'h90);
    tick();
    chk("last_edge_new", 8'hF7, 8'hC0);

    // reset mid-scan at digit 5
    goto_digit(5);
    chk("pre_rst_d5", 8'hFF, 8'hFF);
    segrst = 1'b0;
    tick();
    chk("mid_rst_dark", 8'hFF, 8'hFF);
    tick();
    segrst = 1'b1;
    tick();
    chk("rst_restart_d0", 8'hFE, 8'hC0);
    tick();
    chk("rst_d0_hold", 8'hFE, 8'hC0);
    goto_digit(1);
    chk("rst_mask_d1", 8'hFD, 8'hC0);
    goto_digit(4);
    chk("rst_data_d4", 8'hEF, 8'hC0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/segdisplay.md
Name: segdisplay

Overview:
- Memory-mapped 8-digit seven-segment display writer. It is the CPU-to-board output counterpart of the switch read peripheral.
- MemOrIO drives the chip select, address and write data. The block latches 32 bits of hex digit data, a digit-enable mask and decimal-point bits.
- It time-multiplexes the eight common-anode digits on the board pins.

Parameters:
- SCAN_DIV, 50000, segclk cycles each digit stays lit (legal range 2..2^20); the bench uses 4.

Ports:
- segclk  input  1  system clock; all state updates on the falling edge.
- segrst  input  1  synchronous reset, active-low, sampled on the falling edge of segclk.
- segcs  input  1  display chip select from MemOrIO.
- segwrite  input  1  write strobe.
- segaddr  input  2  register select within the display window.
- segwdata  input  16  write data from the CPU.
- seg_an  output  8  digit anode enables, active-low; bit i drives digit i.
- seg_out  output  8  segment lines, active-low; [7]=dp, [6:0]=g..a.

Behaviour:
- Clocking and reset:
  - Every register updates only on the falling edge of segclk.
  - Reset is sampled there: segrst==0 at a falling edge resets the block.
- Reset values:
  - digit data (32b) = 0, mask = 8'hFF, dp = 8'h00.
  - div counter = 0, digit index = 0.
  - seg_an = 8'hFF, seg_out = 8'hFF (display dark).
  - Reset dominates a simultaneous write and any scan activity.
- Register writes (segcs && segwrite at a falling edge):
  - segaddr 2'b00: data[15:0] <= segwdata (digits 3..0, nibble k = digit k).
  - segaddr 2'b10: data[31:16] <= segwdata (digits 7..4).
  - segaddr 2'b01: mask <= segwdata[7:0]; dp <= segwdata[15:8].
  - segaddr 2'b11: no register changes.
  - segcs==0 or segwrite==0: all registers hold.
- Scan counter:
  - div counts 0..SCAN_DIV-1 every edge.
  - At SCAN_DIV-1, div wraps to 0 and the digit index increments modulo 8 (7 wraps to 0).
  - Writes never disturb div or the index.
- Output registers, updated every non-reset edge from the current index i:
  - seg_an <= mask[i] ? ~(8'b1<<i) : 8'hFF.
  - seg_out <= mask[i] ? {~dp[i], ~hex(data[4i+3:4i])} : 8'hFF.
  - Outputs lag the index by one edge. Exactly one anode or none is low at any time.
- Hex decode table (active-high g..a):
  - 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07
  - 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71
- Write and scan on the same edge: the output register samples the old register contents on that edge. The new value appears on the pins one edge later.
- A full refresh takes 8*SCAN_DIV cycles.
- Reset mid-scan: the index restarts at digit 0, and the display is dark until the first post-reset output edge.

Test Plan:
- Reset: hold segrst=0 for 3 edges, with a write pulsed during reset -> seg_an=8'hFF, seg_out=8'hFF; after release, digit 0 shows 0 (seg_an=8'hFE, seg_out=8'hC0).
- Write segaddr 00 = 16'h4321 and 10 = 16'h8765, SCAN_DIV=4 -> digits step every 4 cycles, seg_an cycling FE,FD,FB,...,7F:
  - seg_out sequence F9,A4,B0,99,92,82,F8,80.
  - Wrap back to digit 0 after 32 cycles.
- Hex A..F: write 00 = 16'hDCBA, 10 = 16'h00FE -> digits 0..5 give seg_out 88,83,C6,A1,86,8E.
- Mask and dp: write 01 = 16'h0105 -> only digits 0 and 2 light.
  - Digit 0 shows seg_out bit7=0 (dp on); digits 1,3-7 give seg_an=FF, seg_out=FF.
- Write gating: pulse segwrite with segcs=0, then segaddr=11 with segcs=1, each with data FFFF -> the display is unchanged. A write on the last cycle of a digit slot appears on the pins one edge later.
- Reset mid-scan at digit 5 -> the next output after release is digit 0 with data 0. The mask returns to FF.
